// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative sign-magnitude multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sizes for the default 8-bit operand configuration.
  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_MAG_W = DEF_W - 1;
  localparam int unsigned DEF_ACC_W = 2 * DEF_W - 2;

  function automatic int unsigned mag_width(input int unsigned w);
    return w - 1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned w);
    return 2 * w - 2;
  endfunction

  // Iterations needed to consume every magnitude bit of the multiplier.
  function automatic int unsigned num_iter(input int unsigned w, input int unsigned digit);
    return (w - 1 + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/mult_digit.sv
// Unsigned magnitude x one multiplier digit partial product.
module mult_digit #(
  parameter int unsigned MAG_W = 7,
  parameter int unsigned DIGIT = 2
) (
  input  logic [MAG_W-1:0]       a,
  input  logic [DIGIT-1:0]       d,
  output logic [MAG_W+DIGIT-1:0] prod_c
);

  localparam int unsigned PP_W = MAG_W + DIGIT;

  assign prod_c = PP_W'(a) * PP_W'(d);

endmodule

// File: rtl/mult_sm_seq.sv
// Iterative sign-magnitude multiplier: DIGIT multiplier bits per cycle,
// valid/ready on both sides, one product in flight.
module mult_sm_seq
  import mult_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned DIGIT    = 2,
  parameter int unsigned ZERO_POS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] w
);

  localparam int unsigned MAG_W = mag_width(W);
  localparam int unsigned ACC_W = acc_width(W);
  localparam int unsigned N     = num_iter(W, DIGIT);
  localparam int unsigned BW    = N * DIGIT;
  localparam int unsigned PP_W  = MAG_W + DIGIT;
  localparam int unsigned EXT_W = MAG_W + BW;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic             ZP       = (ZERO_POS != 0);

  state_t           state;
  logic [MAG_W-1:0] a_mag;
  logic [BW-1:0]    b_rem;
  logic             sign;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;

  logic [DIGIT-1:0] digit_c;
  logic [PP_W-1:0]  pp_c;
  logic [ACC_W-1:0] pp_sh_c;
  logic [ACC_W-1:0] acc_next_c;
  logic             sign_out_c;

  // Lowest unconsumed multiplier digit; b_rem shifts down one digit per CALC cycle.
  assign digit_c = b_rem[DIGIT-1:0];

  mult_digit #(
    .MAG_W (MAG_W),
    .DIGIT (DIGIT)
  ) u_digit (
    .a      (a_mag),
    .d      (digit_c),
    .prod_c (pp_c)
  );

  // Widen before shifting so no partial-product bits are lost; the final
  // sum always fits ACC_W, so truncating each term is exact modulo 2^ACC_W.
  assign pp_sh_c    = ACC_W'(EXT_W'(pp_c) << (count * DIGIT));
  assign acc_next_c = acc + pp_sh_c;
  assign sign_out_c = sign & ~(ZP & (acc_next_c == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      w         <= '0;
      acc       <= '0;
      count     <= '0;
      a_mag     <= '0;
      b_rem     <= '0;
      sign      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_mag    <= a_in[W-2:0];
            b_rem    <= BW'(b_in[W-2:0]);
            sign     <= a_in[W-1] ^ b_in[W-1];
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end

        CALC: begin
          acc   <= acc_next_c;
          b_rem <= b_rem >> DIGIT;
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            w         <= {sign_out_c, 1'b0, acc_next_c};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
